branch_update_unit: RTL
=======================

// Module: branch_update_unit
// PURPOSE
//  Decode-side write end of the branch_table BTB. Resolves each beq in ID against the
//  prediction fetch used, keeps 2-bit saturating counters per BTB line, drives the table's
//  WRt/WRp/Pin/BdestIN/PC4d write port, and issues a one-cycle flush plus redirect PC on a
//  mispredict. Sits between the ID stage compare logic and branch_table.
// PARAMETERS
//  IDX_BITS   4        BTB index width; index = pc4[IDX_BITS+1:2], 16 lines
//  CNT_INIT   2'b01    counter reset/allocation value for not-taken (weak NT)
//  STAT_W     16       width of statistics counters
// PORTS
//  clk            in   1   clock; single clock domain
//  rst            in   1   synchronous, active-high reset
//  stall          in   1   ID stage held; no new branch accepted
//  id_valid       in   1   ID holds a real (non-bubble) instruction
//  id_is_beq      in   1   ID instruction is a beq
//  id_taken       in   1   resolved beq outcome
//  id_target      in   32  resolved branch target
//  id_pc4         in   32  PC+4 of the ID instruction
//  id_hit         in   1   BTB hit seen at fetch (carried via IF/ID)
//  id_pred        in   1   BTB prediction seen at fetch
//  id_pred_dest   in   32  BTB target seen at fetch
//  WRt            out  1   to branch_table: write tag+dest
//  WRp            out  1   to branch_table: write prediction bit
//  Pin            out  1   to branch_table: new prediction bit
//  BdestIN        out  32  to branch_table: target to store
//  PC4d           out  32  to branch_table: PC+4 selecting the line
//  flush          out  1   squash IF/ID, one cycle
//  redirect_pc    out  32  fetch restart PC, valid when flush=1
//  n_branch       out  STAT_W  resolved beq count, wraps
//  n_mispred      out  STAT_W  mispredict count, wraps
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, every counter=CNT_INIT, stats=0. rst in any state
//    wins that cycle: no table write, no flush.
//  - accept = id_valid & id_is_beq & ~stall & (state!=SQUASH). Accepted branch data
//    registered: pc4_r, taken_r, target_r, hit_r, pred_r, pdest_r.
//  - pred_taken = hit_r & pred_r. mispred = (pred_taken!=taken_r) |
//    (pred_taken & taken_r & pdest_r!=target_r).
//  - FSM: IDLE -accept-> UPD. UPD (1 cycle, write cycle) -> SQUASH if mispred,
//    else UPD if accept, else IDLE. SQUASH (1 cycle, ignores ID: wrong-path) -> IDLE.
//  - In UPD (all outputs combinational from registered state): WRp=1; PC4d=pc4_r;
//    WRt=~hit_r | (taken_r & pdest_r!=target_r); BdestIN=target_r;
//    Pin=new_cnt[1]; flush=mispred; redirect_pc = taken_r ? target_r : pc4_r;
//    n_branch+=1; n_mispred+=mispred. Counter write at end of UPD.
//  - Counter update: hit_r -> saturating ++ if taken_r (max 3), -- if not (min 0);
//    ~hit_r (allocation) -> 2'b10 if taken_r, CNT_INIT if not.
//  - Latency: resolution in ID at cycle N -> table write and flush at N+1.
//  - Outside UPD: WRt=WRp=flush=0; BdestIN/PC4d/redirect_pc hold last values.
//  - Back-to-back beqs without mispredict: one write per cycle, none dropped.
//    Same index twice in a row: second update uses the counter written by the first
//    (bypass the just-written value).
//  - stall during UPD does not block the write or flush of the already-resolved branch.
//  - Stats wrap modulo 2^STAT_W, no saturation.
// STRUCTURE
//  - Shared include bpu_defs.vh (`ifndef-guarded): IDX_BITS, CNT_INIT, counter
//    encodings SNT/WNT/WT/ST, FSM state encodings IDLE/UPD/SQUASH.
//  - One sub-module: sat_counter2 (2-bit next-value logic: inc/dec/alloc, saturate).
//  - Counter array 16x2 regs in this module; no memory-file init.
// TESTING
//  1 rst=1 2 cycles -> WRt=WRp=flush=0, n_branch=0, all counters 01.
//  2 miss beq pc4=0x40 taken tgt=0x100 -> N+1: WRt=WRp=1, Pin=1, PC4d=0x40,
//    BdestIN=0x100, flush=1, redirect=0x100; next cycle ID ignored; n_mispred=1.
//  3 hit pred=1 dest=0x100, taken tgt=0x100 -> WRt=0, WRp=1, Pin=1, flush=0,
//    counter 10->11; repeat -> stays 11.
//  4 hit pred=1, not taken pc4=0x40 -> flush=1, redirect=0x40, Pin=1 (11->10);
//    again (hit, pred=1) -> Pin=0 (10->01).
//  5 two beqs same index consecutive cycles, both correct -> two UPD cycles,
//    second uses bypassed counter; n_branch+=2.
//  6 rst asserted during UPD with mispred -> flush=0, WRp=0 that cycle, state IDLE.

Source files
------------

// File: rtl/branch_update_unit_pkg.sv
// Shared definitions for the BTB update path: geometry defaults, 2-bit counter
// encodings and the update FSM states.
package branch_update_unit_pkg;
   localparam int         BPU_IDX_BITS = 4;
   localparam int         BPU_STAT_W   = 16;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } cnt_e;

   localparam logic [1:0] BPU_CNT_INIT = WNT;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      UPD    = 2'b01,
      SQUASH = 2'b10
   } state_e;
endpackage

// File: rtl/branch_update_unit_sat_counter2.sv
// Next-value logic for one 2-bit saturating branch counter.
// Allocation (BTB miss) seeds the counter; a hit steps it toward the resolved outcome.
module sat_counter2
   import branch_update_unit_pkg::*;
#(
   parameter logic [1:0] CNT_INIT = BPU_CNT_INIT
) (
   input  logic [1:0] cnt_i,
   input  logic       hit_i,
   input  logic       taken_i,
   output logic [1:0] cnt_o
);

   always_comb begin
      cnt_o = cnt_i;
      if (!hit_i) begin
         cnt_o = taken_i ? WT : CNT_INIT;
      end else if (taken_i) begin
         cnt_o = (cnt_i == ST) ? ST : cnt_i + 2'd1;
      end else begin
         cnt_o = (cnt_i == SNT) ? SNT : cnt_i - 2'd1;
      end
   end

endmodule

// File: rtl/branch_update_unit.sv
// Decode-side BTB writer: resolves beq against the fetch prediction, updates counters,
// drives the branch_table write port and a one-cycle flush/redirect on mispredict.
module branch_update_unit
   import branch_update_unit_pkg::*;
#(
   parameter int         IDX_BITS = BPU_IDX_BITS,
   parameter logic [1:0] CNT_INIT = BPU_CNT_INIT,
   parameter int         STAT_W   = BPU_STAT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              id_valid,
   input  logic              id_is_beq,
   input  logic              id_taken,
   input  logic [31:0]       id_target,
   input  logic [31:0]       id_pc4,
   input  logic              id_hit,
   input  logic              id_pred,
   input  logic [31:0]       id_pred_dest,
   output logic              WRt,
   output logic              WRp,
   output logic              Pin,
   output logic [31:0]       BdestIN,
   output logic [31:0]       PC4d,
   output logic              flush,
   output logic [31:0]       redirect_pc,
   output logic [STAT_W-1:0] n_branch,
   output logic [STAT_W-1:0] n_mispred
);

   localparam int NLINES = 1 << IDX_BITS;

   state_e              state_q, state_d;
   logic [31:0]         pc4_q, target_q, pdest_q;
   logic                taken_q, hit_q, pred_q;
   logic [1:0]          cnt_q [NLINES];
   logic [31:0]         bdest_hold_q, pc4d_hold_q, redir_hold_q;
   logic [STAT_W-1:0]   n_branch_q, n_mispred_q;

   logic                in_upd, upd_ok, pred_taken, tgt_diff, mispred, accept;
   logic [IDX_BITS-1:0] idx;
   logic [1:0]          new_cnt;
   logic [31:0]         redir;

   assign in_upd     = (state_q == UPD);
   assign upd_ok     = in_upd & ~rst;
   assign idx        = pc4_q[IDX_BITS+1:2];
   assign pred_taken = hit_q & pred_q;
   assign tgt_diff   = (pdest_q != target_q);
   assign mispred    = (pred_taken != taken_q) | (pred_taken & taken_q & tgt_diff);
   assign redir      = taken_q ? target_q : pc4_q;

   // The instruction sitting in ID while a mispredicting branch writes is wrong-path.
   assign accept = id_valid & id_is_beq & ~stall & (state_q != SQUASH)
                 & ~(in_upd & mispred);

   // Counters are flops written at the end of UPD, so a back-to-back update of the
   // same line reads the freshly written value without a separate bypass mux.
   sat_counter2 #(.CNT_INIT(CNT_INIT)) u_cnt (
      .cnt_i   (cnt_q[idx]),
      .hit_i   (hit_q),
      .taken_i (taken_q),
      .cnt_o   (new_cnt)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = UPD;
         UPD: begin
            if (mispred)     state_d = SQUASH;
            else if (accept) state_d = UPD;
            else             state_d = IDLE;
         end
         SQUASH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      WRp         = upd_ok;
      WRt         = upd_ok & (~hit_q | (taken_q & tgt_diff));
      Pin         = upd_ok & new_cnt[1];
      flush       = upd_ok & mispred;
      BdestIN     = bdest_hold_q;
      PC4d        = pc4d_hold_q;
      redirect_pc = redir_hold_q;
      if (rst) begin
         BdestIN     = '0;
         PC4d        = '0;
         redirect_pc = '0;
      end else if (in_upd) begin
         BdestIN     = target_q;
         PC4d        = pc4_q;
         redirect_pc = redir;
      end
   end

   assign n_branch  = n_branch_q;
   assign n_mispred = n_mispred_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         pc4_q        <= '0;
         target_q     <= '0;
         pdest_q      <= '0;
         taken_q      <= 1'b0;
         hit_q        <= 1'b0;
         pred_q       <= 1'b0;
         bdest_hold_q <= '0;
         pc4d_hold_q  <= '0;
         redir_hold_q <= '0;
         n_branch_q   <= '0;
         n_mispred_q  <= '0;
         for (int i = 0; i < NLINES; i++) cnt_q[i] <= CNT_INIT;
      end else begin
         state_q <= state_d;
         if (accept) begin
            pc4_q    <= id_pc4;
            target_q <= id_target;
            pdest_q  <= id_pred_dest;
            taken_q  <= id_taken;
            hit_q    <= id_hit;
            pred_q   <= id_pred;
         end
         if (in_upd) begin
            cnt_q[idx]   <= new_cnt;
            bdest_hold_q <= target_q;
            pc4d_hold_q  <= pc4_q;
            redir_hold_q <= redir;
            n_branch_q   <= n_branch_q + 1'b1;
            n_mispred_q  <= n_mispred_q + STAT_W'(mispred);
         end
      end
   end

endmodule
